// File: rtl/cp0_pkg.sv
// Shared CP0 constants and the in-flight entry tag used by the forwarding pipe.
// Entry data travels beside the tag so its width can follow the DATA_W parameter.
package cp0_pkg;

  typedef logic [4:0] cp0_addr_t;

  localparam cp0_addr_t CP0_STATUS = 5'd12;
  localparam cp0_addr_t CP0_CAUSE  = 5'd13;
  localparam cp0_addr_t CP0_EPC    = 5'd14;
  localparam cp0_addr_t CP0_EBASE  = 5'd15;

  localparam logic [31:0] CP0_STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] CP0_EBASE_RST    = 32'h8000_0000;
  localparam logic [31:0] CP0_STATUS_WMASK = 32'h0000_FF13;
  localparam logic [31:0] CP0_CAUSE_WMASK  = 32'h0000_0300;

  typedef struct packed {
    logic      valid;
    cp0_addr_t addr;
  } cp0_tag_t;

  function automatic logic cp0_is_owned(input cp0_addr_t a);
    return (a == CP0_STATUS) || (a == CP0_CAUSE) || (a == CP0_EPC) || (a == CP0_EBASE);
  endfunction

endpackage

// File: rtl/cp0_fwd_pipe_if.sv
// EX-side MTC0/MFC0 bus between the execute stage (master) and the CP0 forwarding pipe (slave).
interface cp0_fwd_pipe_if
  import cp0_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              advance;
  logic              flush;
  logic              ex_we;
  cp0_addr_t         ex_waddr;
  logic [DATA_W-1:0] ex_wdata;
  cp0_addr_t         rd_addr;
  logic [DATA_W-1:0] rd_ext_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output advance, flush, ex_we, ex_waddr, ex_wdata, rd_addr, rd_ext_data,
    input  rd_data
  );

  modport slave (
    input  advance, flush, ex_we, ex_waddr, ex_wdata, rd_addr, rd_ext_data,
    output rd_data
  );

endinterface

// File: rtl/cp0_fwd_stage.sv
// One in-flight MTC0 slot: a kill drops the entry, otherwise it loads on advance and holds on stall.
module cp0_fwd_stage
  import cp0_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              clear,
  input  cp0_tag_t          in_tag,
  input  logic [DATA_W-1:0] in_data,
  output cp0_tag_t          out_tag,
  output logic [DATA_W-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tag  <= '0;
      out_data <= '0;
    end else if (clear) begin
      out_tag.valid <= 1'b0;
    end else if (advance) begin
      out_tag  <= in_tag;
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/cp0_fwd_pipe.sv
// CP0 forwarding pipeline: arch Status/Cause/EPC/EBase, DEPTH in-flight MTC0 slots,
// youngest-first forwarding to EX and masked software writes.
module cp0_fwd_pipe
  import cp0_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 2,
  parameter logic [DATA_W-1:0] STATUS_RST   = CP0_STATUS_RST,
  parameter logic [DATA_W-1:0] EBASE_RST    = CP0_EBASE_RST,
  parameter logic [DATA_W-1:0] STATUS_WMASK = CP0_STATUS_WMASK,
  parameter logic [DATA_W-1:0] CAUSE_WMASK  = CP0_CAUSE_WMASK
) (
  input  logic              clk,
  input  logic              rst_n,
  cp0_fwd_pipe_if.slave     bus,
  input  logic              exc_valid,
  input  logic [DATA_W-1:0] exc_epc,
  input  logic [DATA_W-1:0] exc_cause,
  input  logic [DATA_W-1:0] exc_status,
  output logic [DATA_W-1:0] status_o,
  output logic [DATA_W-1:0] cause_o,
  output logic [DATA_W-1:0] epc_o,
  output logic [DATA_W-1:0] ebase_o,
  output logic [2:0]        pending_o
);

  logic [DATA_W-1:0] arch_status;
  logic [DATA_W-1:0] arch_cause;
  logic [DATA_W-1:0] arch_epc;
  logic [DATA_W-1:0] arch_ebase;

  cp0_tag_t          tag_s  [DEPTH];
  logic [DATA_W-1:0] data_s [DEPTH];

  cp0_tag_t          cap_tag;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_fwd;
  logic              kill;

  // An exception always squashes the younger in-flight writes, even if flush was not raised.
  assign kill    = bus.flush | exc_valid;
  assign cap_tag = '{valid: bus.ex_we, addr: bus.ex_waddr};

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    cp0_tag_t          in_tag;
    logic [DATA_W-1:0] in_data;

    if (g == 0) begin : g_head
      assign in_tag  = cap_tag;
      assign in_data = merged;
    end else begin : g_body
      assign in_tag  = tag_s[g-1];
      assign in_data = data_s[g-1];
    end

    cp0_fwd_stage #(.DATA_W(DATA_W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (bus.advance),
      .clear    (kill),
      .in_tag   (in_tag),
      .in_data  (in_data),
      .out_tag  (tag_s[g]),
      .out_data (data_s[g])
    );
  end

  // Oldest-to-youngest scan so the lowest-index match overrides everything behind it.
  always_comb begin
    status_o = arch_status;
    cause_o  = arch_cause;
    epc_o    = arch_epc;
    ebase_o  = arch_ebase;
    unique case (bus.rd_addr)
      CP0_STATUS: rd_fwd = arch_status;
      CP0_CAUSE:  rd_fwd = arch_cause;
      CP0_EPC:    rd_fwd = arch_epc;
      CP0_EBASE:  rd_fwd = arch_ebase;
      default:    rd_fwd = bus.rd_ext_data;
    endcase
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tag_s[i].valid) begin
        if (tag_s[i].addr == bus.rd_addr) rd_fwd   = data_s[i];
        if (tag_s[i].addr == CP0_STATUS)  status_o = data_s[i];
        if (tag_s[i].addr == CP0_CAUSE)   cause_o  = data_s[i];
        if (tag_s[i].addr == CP0_EPC)     epc_o    = data_s[i];
        if (tag_s[i].addr == CP0_EBASE)   ebase_o  = data_s[i];
      end
    end
  end

  assign bus.rd_data = rd_fwd;

  // Read-only bits come from the forwarded value so back-to-back MTC0s stack correctly.
  always_comb begin
    unique case (bus.ex_waddr)
      CP0_STATUS: merged = (status_o & ~STATUS_WMASK) | (bus.ex_wdata & STATUS_WMASK);
      CP0_CAUSE:  merged = (cause_o  & ~CAUSE_WMASK)  | (bus.ex_wdata & CAUSE_WMASK);
      default:    merged = bus.ex_wdata;
    endcase
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_o = pending_o + {2'b00, tag_s[i].valid};
    end
  end

  // Exception writes come after the commit so they win on Status/Cause/EPC; EBase commits untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch_status <= STATUS_RST;
      arch_cause  <= '0;
      arch_epc    <= '0;
      arch_ebase  <= EBASE_RST;
    end else begin
      if (bus.advance && tag_s[DEPTH-1].valid) begin
        unique case (tag_s[DEPTH-1].addr)
          CP0_STATUS: arch_status <= data_s[DEPTH-1];
          CP0_CAUSE:  arch_cause  <= data_s[DEPTH-1];
          CP0_EPC:    arch_epc    <= data_s[DEPTH-1];
          CP0_EBASE:  arch_ebase  <= data_s[DEPTH-1];
          default:    ;
        endcase
      end
      if (exc_valid) begin
        arch_status <= exc_status;
        arch_cause  <= exc_cause;
        arch_epc    <= exc_epc;
      end
    end
  end

endmodule

// File: tb/tb_cp0_fwd_pipe.sv
// Directed scoreboard bench for cp0_fwd_pipe at DEPTH=3.
module tb_cp0_fwd_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic [31:0] exc_epc;
  logic [31:0] exc_cause;
  logic [31:0] exc_status;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] ebase_o;
  logic [2:0]  pending_o;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  cp0_fwd_pipe_if #(.DATA_W(32)) bus ();

  cp0_fwd_pipe #(.DATA_W(32), .DEPTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .exc_valid  (exc_valid),
    .exc_epc    (exc_epc),
    .exc_cause  (exc_cause),
    .exc_status (exc_status),
    .status_o   (status_o),
    .cause_o    (cause_o),
    .epc_o      (epc_o),
    .ebase_o    (ebase_o),
    .pending_o  (pending_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic adv, input logic fl, input logic we,
                               input logic [4:0] waddr, input logic [31:0] wdata);
    bus.advance  = adv;
    bus.flush    = fl;
    bus.ex_we    = we;
    bus.ex_waddr = waddr;
    bus.ex_wdata = wdata;
  endtask

  task automatic expectValue(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    exc_valid       = 1'b0;
    exc_epc         = '0;
    exc_cause       = '0;
    exc_status      = '0;
    bus.rd_addr     = 5'd15;
    bus.rd_ext_data = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Reset state
    expectValue("rst_rd_ebase", 32'h8000_0000); checkOutput(bus.rd_data);
    expectValue("rst_status",   32'h0040_0000); checkOutput(status_o);
    expectValue("rst_cause",    32'h0);         checkOutput(cause_o);
    expectValue("rst_epc",      32'h0);         checkOutput(epc_o);
    expectValue("rst_pending",  32'h0);         checkOutput({29'b0, pending_o});
    bus.rd_addr = 5'd3;
    #1;
    expectValue("rst_rd_ext", 32'hDEAD_BEEF);   checkOutput(bus.rd_data);

    // Back-to-back EPC writes, then a non-owned write
    bus.rd_addr = 5'd14;
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd14, 32'h100);
    expectValue("epc_fwd_first", 32'h100);
    expectValue("epc_pend_1",    32'h1);
    tick();
    checkOutput(bus.rd_data);
    checkOutput({29'b0, pending_o});
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd14, 32'h200);
    expectValue("epc_fwd_young", 32'h200);
    expectValue("epc_pend_2",    32'h2);
    expectValue("epc_view",      32'h200);
    tick();
    checkOutput(bus.rd_data);
    checkOutput({29'b0, pending_o});
    checkOutput(epc_o);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'h1234);
    expectValue("ext_addr_fwd", 32'h1234);
    expectValue("epc_pend_3",   32'h3);
    tick();
    bus.rd_addr = 5'd9;
    #1;
    checkOutput(bus.rd_data);
    checkOutput({29'b0, pending_o});
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    expectValue("epc_after_c1", 32'h200);
    expectValue("drain_pend_2", 32'h2);
    tick();
    checkOutput(epc_o);
    checkOutput({29'b0, pending_o});
    tick();
    tick();
    expectValue("ext_after_drain", 32'hDEAD_BEEF); checkOutput(bus.rd_data);
    expectValue("epc_arch",        32'h200);       checkOutput(epc_o);
    expectValue("drain_pend_0",    32'h0);         checkOutput({29'b0, pending_o});

    // Masked writes to Cause and Status, stacking on forwarded values
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF);
    expectValue("cause_masked", 32'h0000_0300);
    tick();
    checkOutput(cause_o);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF);
    expectValue("status_masked", 32'h0040_FF13);
    tick();
    checkOutput(status_o);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 32'h0);
    expectValue("status_restack", 32'h0040_0000);
    expectValue("mask_pend_3",    32'h3);
    tick();
    checkOutput(status_o);
    checkOutput({29'b0, pending_o});
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) tick();
    expectValue("cause_arch",  32'h0000_0300); checkOutput(cause_o);
    expectValue("status_arch", 32'h0040_0000); checkOutput(status_o);

    // Exception on the same edge as a Status commit
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    expectValue("status_in_wb", 32'h0040_0001); checkOutput(status_o);
    exc_valid  = 1'b1;
    exc_status = 32'h2;
    exc_cause  = 32'h1C;
    exc_epc    = 32'hBFC0_0180;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    expectValue("exc_status",  32'h2);
    expectValue("exc_cause",   32'h1C);
    expectValue("exc_epc",     32'hBFC0_0180);
    expectValue("exc_pending", 32'h0);
    tick();
    exc_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput(status_o);
    checkOutput(cause_o);
    checkOutput(epc_o);
    checkOutput({29'b0, pending_o});

    // Exception on the same edge as an EBase commit
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd15, 32'h9000_0000);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    exc_valid  = 1'b1;
    exc_status = 32'h3;
    exc_cause  = 32'h0;
    exc_epc    = 32'h44;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    expectValue("exc_ebase_commit", 32'h9000_0000);
    expectValue("exc_status_2",     32'h3);
    tick();
    exc_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput(ebase_o);
    checkOutput(status_o);

    // Flush with three valid writes: only the oldest commits
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd14, 32'h11);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd14, 32'h22);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd14, 32'h33);
    tick();
    expectValue("flush_pre_pend", 32'h3); checkOutput({29'b0, pending_o});
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd14, 32'h44);
    expectValue("flush_epc",  32'h11);
    expectValue("flush_pend", 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput(epc_o);
    checkOutput({29'b0, pending_o});

    // Stall holds a pending write, then asynchronous reset
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd15, 32'hA000_0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd15, 32'hB000_0000);
    repeat (5) tick();
    expectValue("stall_pend",  32'h1);         checkOutput({29'b0, pending_o});
    expectValue("stall_ebase", 32'hA000_0000); checkOutput(ebase_o);
    bus.rd_addr = 5'd14;
    #2;
    rst_n = 1'b0;
    #1;
    expectValue("arst_ebase",   32'h8000_0000); checkOutput(ebase_o);
    expectValue("arst_status",  32'h0040_0000); checkOutput(status_o);
    expectValue("arst_cause",   32'h0);         checkOutput(cause_o);
    expectValue("arst_epc",     32'h0);         checkOutput(epc_o);
    expectValue("arst_pending", 32'h0);         checkOutput({29'b0, pending_o});
    expectValue("arst_rd_epc",  32'h0);         checkOutput(bus.rd_data);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #3;
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cp0_fwd_pipe.md
# cp0_fwd_pipe

Parametrised CP0 forwarding pipeline for the MIPS32 core. It owns the architectural copies of Status, Cause, EPC and EBase. It tracks in-flight MTC0 writes across a configurable number of post-EX stages and returns youngest-first forwarded values to EX. It applies per-register software write masks and accepts direct exception-unit updates. It sits beside the EX stage and replaces the purely combinational CP0 bypass.

## Interface
Parameters:
- `DATA_W`, 32, CP0 data width
- `DEPTH`, 2, in-flight stages after EX (2 = MEM, WB); legal range 1..4
- `STATUS_RST`, 32'h0040_0000, Status reset value
- `EBASE_RST`, 32'h8000_0000, EBase reset value
- `STATUS_WMASK`, 32'h0000_FF13, MTC0-writable Status bits
- `CAUSE_WMASK`, 32'h0000_0300, MTC0-writable Cause bits (IP1:0)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `advance`  in  1  pipeline enable (inverse of global stall)
- `flush`  in  1  kill all in-flight entries younger than the committing one
- `ex_we`  in  1  MTC0 in EX
- `ex_waddr`  in  5  CP0 register number
- `ex_wdata`  in  DATA_W  MTC0 source data
- `rd_addr`  in  5  MFC0 register number in EX
- `rd_ext_data`  in  DATA_W  value from external CP0 file for non-owned addresses
- `rd_data`  out  DATA_W  forwarded MFC0 result
- `exc_valid`  in  1  exception/ERET update this cycle
- `exc_epc`, `exc_cause`, `exc_status`  in  DATA_W  full values from exception unit
- `status_o`, `cause_o`, `epc_o`, `ebase_o`  out  DATA_W  forwarded views
- `pending_o`  out  3  count of valid in-flight entries

## Operation
- Owned addresses: Status=12, Cause=13, EPC=14, EBase=15. Other addresses are tracked for forwarding but never committed here.
- Stage array `s[0..DEPTH-1]`, each entry {valid, addr, data}. `s[DEPTH-1]` is the committing (WB) slot.
- Capture: on an `advance` edge, `s[0]` takes {ex_we, ex_waddr, merged}. `merged` is the data written into the entry:
  - Status: `(fwd & ~STATUS_WMASK) | (ex_wdata & STATUS_WMASK)`
  - Cause: `(fwd & ~CAUSE_WMASK) | (ex_wdata & CAUSE_WMASK)`
  - EPC, EBase and non-owned addresses: `ex_wdata` unmasked
  - `fwd` is the current forwarded value of that register.
- Shift: on an `advance` edge, `s[i+1] <= s[i]`.
- Commit: on an `advance` edge, a valid `s[DEPTH-1]` with an owned address writes its arch register.
- Forwarding: `rd_data` = data of the lowest-index valid stage whose addr matches `rd_addr`. If no stage matches, owned addresses return the arch register and all others return `rd_ext_data`. The views `status_o`/`cause_o`/`epc_o`/`ebase_o` use the same rule with fixed addresses.
- Exception update: when `exc_valid`, EPC, Cause and Status take the `exc_*` values at the edge.
  - This takes priority over a same-edge commit to the same register.
  - A same-edge commit to EBase still happens.
  - `exc_valid` implies `flush`.
- Flush: at the edge, `s[0..DEPTH-2]` are cleared. `s[DEPTH-1]` still commits if `advance`; it is then dropped. Capture is suppressed that cycle.
- `advance=0` without flush: all stages and arch registers hold, except exception updates.
- `pending_o` = popcount of valid bits.

## Timing
- Forward outputs are combinational from stage/arch state. There is no EX-to-EX self-forward.
- An MTC0 in EX at cycle t (advance each cycle) is visible to `rd_data` from t+1 and in arch from the edge ending cycle t+DEPTH.
- Reset (asynchronous, any time, including mid-flush):
  - all valid bits cleared
  - Status=STATUS_RST, EBase=EBASE_RST, Cause=0, EPC=0
  - `rd_data` = arch/ext value, `pending_o`=0
- When two stages match the same address, the youngest (lowest index) always wins.

## Structure
- Package `cp0_pkg`: address constants (CP0_STATUS/CAUSE/EPC/EBASE), reset values and write masks, and the in-flight entry struct typedef.
- One sub-module, `cp0_fwd_stage`: a single stage register with valid, advance/flush/clear handling, instantiated DEPTH times via generate.
- Top module holds the arch registers, priority mux and mask merge.

## Test plan
- Reset then read: `rd_addr`=15 -> `rd_data`=32'h8000_0000, `status_o`=32'h0040_0000, `pending_o`=0.
- Back-to-back MTC0 EPC of 32'h100 then 32'h200, `rd_addr`=14 -> `rd_data`=32'h200 while both are in flight; arch EPC=32'h200 after DEPTH+1 edges.
- MTC0 Cause with 32'hFFFF_FFFF from reset -> `cause_o`=32'h0000_0300 next cycle.
- MTC0 Status in `s[DEPTH-1]` and `exc_valid` with `exc_status`=32'h2 on the same edge -> Status=32'h2, `pending_o`=0.
- `flush` with three valid writes at DEPTH=3 -> only the oldest commits; `pending_o`=0 after the edge.
- `advance`=0 for 5 cycles with a pending write, `rst_n` pulsed low asynchronously -> all outputs at reset values immediately.
